// File: rtl/sha256_core.sv
// sha256_core: iterative SHA-256 / SHA-224 compression core.
// Each call compresses one padded 512-bit block. ROUNDS_PER_CYCLE rounds run
// per clock, and a 16-word sliding window supplies the message schedule.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     block handshake; in_block W0 is in bits [511:480]
//   in_first/in_last      message framing tags for the offered block
//   mode_224              SHA-224 select, sampled on a first block only
//   out_valid/out_ready   digest handshake
//   digest                H0..H7 (H0 in [255:224]); SHA-224 zeroes [31:0]
module sha256_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SUPPORT_224      = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         mode_224,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest
);

  localparam int R = ROUNDS_PER_CYCLE;
  localparam logic [5:0] RSTEP = 6'(R);
  localparam logic [5:0] RLAST = 6'(64 - R);

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

  state_t        state_reg;
  logic [5:0]    rnd_cnt_reg;
  logic          out_valid_reg;
  logic          mode_reg;
  logic          last_reg;
  logic [31:0]   h_reg [0:7];
  logic [255:0]  work_reg;
  logic [31:0]   w_reg [0:15];

  // w_ext: current window followed by the R schedule words computed this cycle
  logic [31:0]   w_ext [0:15+R];
  // rv[i]: {a..h} after i of this cycle's rounds
  logic [255:0]  rv [0:R];
  logic [255:0]  iv_sel;
  logic          accept;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [255:0] sha_round(input logic [255:0] s,
                                             input logic [31:0] k,
                                             input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  // rst_n gates in_ready so nothing is accepted while reset is held.
  assign in_ready  = rst_n && (state_reg == IDLE);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_reg;
  assign iv_sel    = (SUPPORT_224 && mode_224) ? IV224 : IV256;
  assign digest    = mode_reg ? {h_reg[0], h_reg[1], h_reg[2], h_reg[3], h_reg[4], h_reg[5], h_reg[6], 32'h0}
                              : {h_reg[0], h_reg[1], h_reg[2], h_reg[3], h_reg[4], h_reg[5], h_reg[6], h_reg[7]};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_win
      assign w_ext[gi] = w_reg[gi];
    end
    // New words may depend on words created earlier in the same cycle.
    for (gi = 0; gi < R; gi++) begin : g_sched
      assign w_ext[16+gi] = ssig1(w_ext[14+gi]) + w_ext[9+gi] + ssig0(w_ext[1+gi]) + w_ext[gi];
    end
    assign rv[0] = work_reg;
    for (gi = 0; gi < R; gi++) begin : g_round
      assign rv[gi+1] = sha_round(rv[gi], K[rnd_cnt_reg + 6'(gi)], w_ext[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rnd_cnt_reg   <= 6'd0;
      out_valid_reg <= 1'b0;
      mode_reg      <= 1'b0;
      last_reg      <= 1'b0;
      for (int i = 0; i < 8; i++) h_reg[i] <= IV256[255-32*i -: 32];
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg   <= ROUND;
            rnd_cnt_reg <= 6'd0;
            last_reg    <= in_last;
            if (in_first) begin
              // H takes the IV too, so the final add-back works for every block.
              mode_reg <= SUPPORT_224 && mode_224;
              for (int i = 0; i < 8; i++) h_reg[i] <= iv_sel[255-32*i -: 32];
            end
          end
        end
        ROUND: begin
          rnd_cnt_reg <= rnd_cnt_reg + RSTEP;
          if (rnd_cnt_reg == RLAST) begin
            for (int i = 0; i < 8; i++) h_reg[i] <= h_reg[i] + rv[R][255-32*i -: 32];
            state_reg     <= last_reg ? OUT : IDLE;
            out_valid_reg <= last_reg;
          end
        end
        OUT: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      work_reg <= in_first ? iv_sel
                           : {h_reg[0], h_reg[1], h_reg[2], h_reg[3], h_reg[4], h_reg[5], h_reg[6], h_reg[7]};
      for (int i = 0; i < 16; i++) w_reg[i] <= in_block[511-32*i -: 32];
    end else if (state_reg == ROUND) begin
      work_reg <= rv[R];
      for (int i = 0; i < 16; i++) w_reg[i] <= w_ext[i+R];
    end
  end

endmodule

// File: tb/tb_sha256_core.sv
// tb_sha256_core: vector table plus scoreboard bench for sha256_core, with
// hand-written sequences for output back-pressure, reset abort and the
// latency of every unroll factor.
module tb_sha256_core;

  localparam int RPC = 1;
  localparam int NLAT = 64 / RPC;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_block;
  logic         in_first;
  logic         in_last;
  logic         mode_224;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] digest;

  logic         aux_valid;
  logic [3:0]   aux_rdy;
  logic [3:0]   aux_ov;
  logic [255:0] aux_dig [0:3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_core #(.ROUNDS_PER_CYCLE(RPC), .SUPPORT_224(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_first(in_first), .in_last(in_last),
    .mode_224(mode_224), .out_valid(out_valid), .out_ready(out_ready),
    .digest(digest));

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_aux
      sha256_core #(.ROUNDS_PER_CYCLE(2 << gi), .SUPPORT_224(1)) u_aux (
        .clk(clk), .rst_n(rst_n), .in_valid(aux_valid), .in_ready(aux_rdy[gi]),
        .in_block(in_block), .in_first(in_first), .in_last(in_last),
        .mode_224(mode_224), .out_valid(aux_ov[gi]), .out_ready(1'b1),
        .digest(aux_dig[gi]));
    end
  endgenerate

  localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
  localparam logic [511:0] BLK_2A = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_2B = {{15{32'h0}}, 32'h000001c0};
  localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_2BLK = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] D_224 = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef struct {
    logic [511:0] blk;
    logic         first;
    logic         last;
    logic         mode;
    logic [255:0] exp;
  } vec_t;

  typedef struct {
    logic [255:0] dig;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  vec_t vec [0:7];
  logic ov_prev = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Scoreboard side: every rising out_valid must match the oldest pending entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && !ov_prev) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out_valid: got digest %h at cyc %0d want none", digest, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        $display("digest %h cyc %0d", digest, cyc);
        check("digest", digest, e.dig);
        check("latency", 256'(cyc - e.acc), 256'(NLAT));
      end
    end
    ov_prev <= out_valid;
  end

  task automatic send(input logic [511:0] blk, input logic f, input logic l, input logic m,
                      input logic [255:0] exp, output int acc);
    int n;
    n = 0;
    acc = -1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 256'(in_ready), 256'(1));
    if (!in_ready) return;
    in_valid = 1'b1;
    in_block = blk;
    in_first = f;
    in_last  = l;
    mode_224 = m;
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
    if (l) sbq.push_back('{exp, acc});
    $display("accept first=%0d last=%0d mode=%0d w0=%h cyc=%0d", f, l, m, blk[511:480], acc);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((sbq.size() != 0 || !in_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 256'(sbq.size()), 256'(0));
  endtask

  initial begin
    int acc;
    int prev_acc;
    int p;
    int lat [0:3];

    rst_n = 1'b0; in_valid = 1'b0; aux_valid = 1'b0; out_ready = 1'b1;
    in_block = '0; in_first = 1'b0; in_last = 1'b0; mode_224 = 1'b0;

    vec[0] = '{BLK_ABC,   1'b1, 1'b1, 1'b0, D_ABC};
    vec[1] = '{BLK_EMPTY, 1'b1, 1'b1, 1'b0, D_EMPTY};
    vec[2] = '{BLK_2A,    1'b1, 1'b0, 1'b0, 256'h0};
    vec[3] = '{BLK_2B,    1'b0, 1'b1, 1'b0, D_2BLK};
    vec[4] = '{BLK_ABC,   1'b1, 1'b1, 1'b1, D_224};
    vec[5] = '{BLK_ABC,   1'b1, 1'b1, 1'b0, D_ABC};
    vec[6] = '{BLK_2A,    1'b1, 1'b0, 1'b0, 256'h0};
    vec[7] = '{BLK_2B,    1'b0, 1'b1, 1'b1, D_2BLK};  // mode ignored off a first block

    repeat (3) @(negedge clk);
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 256'(in_ready), 256'(1));
    check("post_rst_digest", digest, IV256);

    // Table-driven messages, back-to-back.
    prev_acc = 0;
    for (int i = 0; i < 8; i++) begin
      send(vec[i].blk, vec[i].first, vec[i].last, vec[i].mode, vec[i].exp, acc);
      if (!vec[i].first) check("throughput", 256'(acc - prev_acc), 256'(NLAT + 1));
      prev_acc = acc;
    end
    wait_idle();

    // Back-pressure: digest must hold while out_ready stays low.
    out_ready = 1'b0;
    send(BLK_ABC, 1'b1, 1'b1, 1'b0, D_ABC, acc);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    check("hold_out_valid_seen", 256'(out_valid), 256'(1));
    in_valid = 1'b1;
    in_block = BLK_EMPTY;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", 256'(out_valid), 256'(1));
      check("hold_digest", digest, D_ABC);
      check("hold_in_ready", 256'(in_ready), 256'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_out_valid", 256'(out_valid), 256'(0));
    check("release_in_ready", 256'(in_ready), 256'(1));
    wait_idle();

    // Reset mid-round aborts the two-block message.
    send(BLK_2A, 1'b1, 1'b0, 1'b0, 256'h0, acc);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 256'(in_ready), 256'(0));
    check("abort_out_valid", 256'(out_valid), 256'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort_post_in_ready", 256'(in_ready), 256'(1));
    check("abort_post_digest", digest, IV256);
    send(BLK_ABC, 1'b1, 1'b1, 1'b0, D_ABC, acc);
    wait_idle();

    // Every other unroll factor: latency and digest of "abc".
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("aux_ready", 256'(aux_rdy[k]), 256'(1));
      lat[k] = -1;
    end
    aux_valid = 1'b1;
    in_block = BLK_ABC; in_first = 1'b1; in_last = 1'b1; mode_224 = 1'b0;
    @(posedge clk);
    #1;
    p = cyc;
    aux_valid = 1'b0;
    $display("accept aux abc cyc=%0d", p);
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (lat[k] < 0 && aux_ov[k]) begin
          lat[k] = cyc - p;
          $display("digest aux%0d %h lat=%0d", k, aux_dig[k], lat[k]);
          check("aux_digest", aux_dig[k], D_ABC);
        end
      end
    end
    for (int k = 0; k < 4; k++) check("aux_latency", 256'(lat[k]), 256'(32 >> k));

    check("scoreboard_empty", 256'(sbq.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
